// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: wait-stated local data memory, freeze generation and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests complete at once with no write and raise misalign.
module mem_stage #(
    parameter int WORD_LEN     = 32,
    parameter int DEPTH        = 64,
    parameter int WAIT_STATES  = 2,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    MEM_R_EN,
    input  logic                    MEM_W_EN,
    input  logic                    WB_EN_in,
    input  logic [REG_ADDR_LEN-1:0] dest_in,
    input  logic [WORD_LEN-1:0]     ALU_res,
    input  logic [WORD_LEN-1:0]     ST_value,
    output logic                    freeze,
    output logic                    WB_EN_out,
    output logic                    MEM_R_EN_out,
    output logic [REG_ADDR_LEN-1:0] dest_out,
    output logic [WORD_LEN-1:0]     ALU_res_out,
    output logic [WORD_LEN-1:0]     data_out,
    output logic                    misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_STATES);

    // Handshake: there is no valid/ready pair here. A request (load or store) is
    // presented by upstream and must stay stable while freeze is high; the access
    // commits on the first rising edge at which the request is present with freeze low.

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                req, misal, eff_req, store, mem_we;
    logic [AW-1:0]       idx;
    logic [WORD_LEN-1:0] rdata;
    logic [WORD_LEN-1:0] mem [DEPTH];

    logic                    wb_q, wb_d, rd_q, rd_d, mis_q, mis_d;
    logic [REG_ADDR_LEN-1:0] dest_q, dest_d;
    logic [WORD_LEN-1:0]     alu_q, alu_d, data_q, data_d;

    logic unused_bits;
    assign unused_bits = ^{ALU_res[WORD_LEN-1:AW+2], ALU_res[1:0]};

    assign req   = MEM_R_EN | MEM_W_EN;
    assign store = MEM_W_EN;
    assign idx   = ALU_res[AW+1:2];
    assign rdata = mem[idx];

`ifdef MEM_ALIGN_CHECK_EN
    assign misal = req & (ALU_res[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign eff_req = req & ~misal;

    // FSM state register: cnt_q == 0 is IDLE, anything else is BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (freeze) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Gating the write with rst keeps a held store from landing while reset is asserted.
    always_comb begin
        freeze = eff_req & (cnt_q != CNT_MAX);
        mem_we = eff_req & store & ~freeze & rst;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= ST_value;
        end
    end

    // A stall inserts a bubble: control bits drop, payload holds.
    always_comb begin
        wb_d   = wb_q;
        rd_d   = rd_q;
        mis_d  = mis_q;
        dest_d = dest_q;
        alu_d  = alu_q;
        data_d = data_q;
        if (freeze) begin
            wb_d  = 1'b0;
            rd_d  = 1'b0;
            mis_d = 1'b0;
        end else begin
            wb_d   = WB_EN_in & ~misal;
            rd_d   = MEM_R_EN & ~MEM_W_EN & ~misal;
            mis_d  = misal;
            dest_d = dest_in;
            alu_d  = ALU_res;
            data_d = misal ? '0 : rdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q   <= 1'b0;
            rd_q   <= 1'b0;
            mis_q  <= 1'b0;
            dest_q <= '0;
            alu_q  <= '0;
            data_q <= '0;
        end else begin
            wb_q   <= wb_d;
            rd_q   <= rd_d;
            mis_q  <= mis_d;
            dest_q <= dest_d;
            alu_q  <= alu_d;
            data_q <= data_d;
        end
    end

    assign WB_EN_out    = wb_q;
    assign MEM_R_EN_out = rd_q;
    assign dest_out     = dest_q;
    assign ALU_res_out  = alu_q;
    assign data_out     = data_q;
    assign misalign     = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with the default parameters (WAIT_STATES=2, DEPTH=64).
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN, MEM_W_EN, WB_EN_in;
    logic [4:0]  dest_in;
    logic [31:0] ALU_res, ST_value;
    logic        freeze, WB_EN_out, MEM_R_EN_out, misalign;
    logic [4:0]  dest_out;
    logic [31:0] ALU_res_out, data_out;

    int tests_run = 0;
    int failures  = 0;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .WB_EN_in(WB_EN_in),
        .dest_in(dest_in), .ALU_res(ALU_res), .ST_value(ST_value),
        .freeze(freeze), .WB_EN_out(WB_EN_out), .MEM_R_EN_out(MEM_R_EN_out),
        .dest_out(dest_out), .ALU_res_out(ALU_res_out), .data_out(data_out),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Drives one instruction, counts freeze cycles and returns just after the capture edge.
    task automatic access(input logic r, input logic w, input logic wb, input logic [4:0] d,
                          input logic [31:0] a, input logic [31:0] st, output int fc);
        MEM_R_EN = r; MEM_W_EN = w; WB_EN_in = wb; dest_in = d; ALU_res = a; ST_value = st;
        fc = 0;
        #1;
        while (freeze === 1'b1 && fc < 20) begin
            fc++;
            @(posedge clk); #1;
            tests_run++;
            if (WB_EN_out !== 1'b0) begin
                failures++;
                $display("FAIL stall_bubble: WB_EN_out=%0b expected 0", WB_EN_out);
            end
        end
        if (fc >= 20) begin
            failures++;
            $display("FAIL freeze_timeout: freeze still high after %0d cycles", fc);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        tests_run++;
        if ({WB_EN_out, MEM_R_EN_out, misalign, freeze} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: wb/rd/mis/frz=%b expected 0000",
                     {WB_EN_out, MEM_R_EN_out, misalign, freeze});
        end
        tests_run++;
        if ({dest_out, ALU_res_out, data_out} !== 69'b0) begin
            failures++;
            $display("FAIL reset_data: dest=%0h alu=%0h data=%0h expected 0", dest_out, ALU_res_out, data_out);
        end
    endtask

    task automatic test_store();
        int fc;
        access(1'b0, 1'b1, 1'b0, 5'd2, 32'h10, 32'hDEADBEEF, fc);
        tests_run++;
        if (fc !== 2) begin failures++; $display("FAIL store_freeze: %0d cycles expected 2", fc); end
        tests_run++;
        if (WB_EN_out !== 1'b0 || MEM_R_EN_out !== 1'b0) begin
            failures++; $display("FAIL store_ctrl: wb=%0b rd=%0b expected 0 0", WB_EN_out, MEM_R_EN_out);
        end
        tests_run++;
        if (ALU_res_out !== 32'h10) begin failures++; $display("FAIL store_alu: %0h expected 10", ALU_res_out); end
    endtask

    task automatic test_load();
        int fc;
        access(1'b1, 1'b0, 1'b1, 5'd7, 32'h10, 32'h0, fc);
        tests_run++;
        if (fc !== 2) begin failures++; $display("FAIL load_freeze: %0d cycles expected 2", fc); end
        tests_run++;
        if (data_out !== 32'hDEADBEEF) begin failures++; $display("FAIL load_data: %0h expected deadbeef", data_out); end
        tests_run++;
        if (MEM_R_EN_out !== 1'b1 || WB_EN_out !== 1'b1 || dest_out !== 5'd7) begin
            failures++;
            $display("FAIL load_ctrl: rd=%0b wb=%0b dest=%0d expected 1 1 7", MEM_R_EN_out, WB_EN_out, dest_out);
        end
    endtask

    task automatic test_alu();
        int fc;
        access(1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h0, fc);
        tests_run++;
        if (fc !== 0) begin failures++; $display("FAIL alu_freeze: %0d cycles expected 0", fc); end
        tests_run++;
        if (ALU_res_out !== 32'h1234 || WB_EN_out !== 1'b1 || MEM_R_EN_out !== 1'b0 || dest_out !== 5'd3) begin
            failures++;
            $display("FAIL alu_out: alu=%0h wb=%0b rd=%0b dest=%0d expected 1234 1 0 3",
                     ALU_res_out, WB_EN_out, MEM_R_EN_out, dest_out);
        end
    endtask

    task automatic test_reset_mid();
        int fc;
        access(1'b0, 1'b1, 1'b1, 5'd5, 32'h20, 32'h11111111, fc);
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b1; WB_EN_in = 1'b1; dest_in = 5'd9;
        ALU_res = 32'h20; ST_value = 32'h22222222;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if ({WB_EN_out, MEM_R_EN_out, misalign} !== 3'b0 || {dest_out, ALU_res_out, data_out} !== 69'b0) begin
            failures++;
            $display("FAIL reset_mid: wb=%0b rd=%0b mis=%0b dest=%0h alu=%0h data=%0h expected all 0",
                     WB_EN_out, MEM_R_EN_out, misalign, dest_out, ALU_res_out, data_out);
        end
        repeat (2) @(posedge clk);
        #1;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN_in = 1'b0; ALU_res = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 1'b1, 5'd4, 32'h20, 32'h0, fc);
        tests_run++;
        if (fc !== 2) begin failures++; $display("FAIL reset_restart: %0d freeze cycles expected 2", fc); end
        tests_run++;
        if (data_out !== 32'h11111111) begin failures++; $display("FAIL reset_nowrite: %0h expected 11111111", data_out); end
    endtask

    task automatic test_wrap();
        int fc;
        access(1'b0, 1'b1, 1'b0, 5'd0, 32'h100, 32'h55, fc);
        access(1'b1, 1'b0, 1'b1, 5'd1, 32'h000, 32'h0, fc);
        tests_run++;
        if (data_out !== 32'h55) begin failures++; $display("FAIL wrap_data: %0h expected 55", data_out); end
    endtask

    task automatic test_read_write_both();
        int fc;
        access(1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'h77, fc);
        access(1'b1, 1'b1, 1'b1, 5'd6, 32'h40, 32'hA5A5, fc);
        tests_run++;
        if (data_out !== 32'h77 || MEM_R_EN_out !== 1'b0) begin
            failures++; $display("FAIL rw_both: data=%0h rd=%0b expected 77 0", data_out, MEM_R_EN_out);
        end
        access(1'b1, 1'b0, 1'b1, 5'd6, 32'h40, 32'h0, fc);
        tests_run++;
        if (data_out !== 32'hA5A5) begin failures++; $display("FAIL rw_both_store: %0h expected a5a5", data_out); end
    endtask

    task automatic test_back_to_back();
        int fc1, fc2, fc3;
        access(1'b0, 1'b1, 1'b0, 5'd0, 32'h30, 32'hCAFEF00D, fc1);
        access(1'b1, 1'b0, 1'b1, 5'd12, 32'h30, 32'h0, fc2);
        tests_run++;
        if (fc1 !== 2 || fc2 !== 2 || data_out !== 32'hCAFEF00D || dest_out !== 5'd12) begin
            failures++;
            $display("FAIL b2b: fc=%0d,%0d data=%0h dest=%0d expected 2,2 cafef00d 12", fc1, fc2, data_out, dest_out);
        end
        access(1'b0, 1'b0, 1'b1, 5'd13, 32'h99, 32'h0, fc3);
        tests_run++;
        if (fc3 !== 0 || ALU_res_out !== 32'h99 || MEM_R_EN_out !== 1'b0) begin
            failures++;
            $display("FAIL b2b_alu: fc=%0d alu=%0h rd=%0b expected 0 99 0", fc3, ALU_res_out, MEM_R_EN_out);
        end
    endtask

    task automatic test_misalign();
        int fc;
        access(1'b1, 1'b0, 1'b1, 5'd4, 32'h13, 32'h0, fc);
`ifdef MEM_ALIGN_CHECK_EN
        tests_run++;
        if (fc !== 0 || misalign !== 1'b1 || WB_EN_out !== 1'b0 || data_out !== 32'h0 || MEM_R_EN_out !== 1'b0) begin
            failures++;
            $display("FAIL misalign: fc=%0d mis=%0b wb=%0b data=%0h rd=%0b expected 0 1 0 0 0",
                     fc, misalign, WB_EN_out, data_out, MEM_R_EN_out);
        end
        access(1'b1, 1'b0, 1'b1, 5'd4, 32'h10, 32'h0, fc);
        tests_run++;
        if (misalign !== 1'b0 || data_out !== 32'hDEADBEEF) begin
            failures++; $display("FAIL misalign_clear: mis=%0b data=%0h expected 0 deadbeef", misalign, data_out);
        end
`else
        tests_run++;
        if (fc !== 2 || misalign !== 1'b0 || data_out !== 32'hDEADBEEF || WB_EN_out !== 1'b1) begin
            failures++;
            $display("FAIL unaligned_load: fc=%0d mis=%0b data=%0h wb=%0b expected 2 0 deadbeef 1",
                     fc, misalign, data_out, WB_EN_out);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; WB_EN_in = 1'b0;
        dest_in = '0; ALU_res = '0; ST_value = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        test_store();
        test_load();
        test_alu();
        test_reset_mid();
        test_wrap();
        test_read_write_both();
        test_back_to_back();
        test_misalign();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline, directly downstream of the execute stage. Takes the execute stage's ALU result as the data-memory address and its forwarded store value as write data. Accesses a local word-addressed data memory with a configurable number of wait states and holds the pipeline with `freeze` while an access is in flight. Registers the outcome into the MEM/WB boundary for write-back and for forwarding back into execute.

## Interface
- `WORD_LEN`, 32: data and address width.
- `DEPTH`, 64: data-memory words; power of two, ≥ 2.
- `WAIT_STATES`, 2: extra cycles per load/store; 0 allowed.
- `REG_ADDR_LEN`, 5: destination register index width.

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `MEM_R_EN` input 1: instruction is a load.
- `MEM_W_EN` input 1: instruction is a store.
- `WB_EN_in` input 1: instruction writes a register.
- `dest_in` input `REG_ADDR_LEN`: destination register.
- `ALU_res` input `WORD_LEN`: execute-stage ALU result, byte address.
- `ST_value` input `WORD_LEN`: store data after forwarding.
- `freeze` output 1: combinational; stall all upstream stage registers and the PC.
- `WB_EN_out` output 1: registered write-enable to WB.
- `MEM_R_EN_out` output 1: registered; WB selects `data_out` when set.
- `dest_out` output `REG_ADDR_LEN`: registered destination.
- `ALU_res_out` output `WORD_LEN`: registered ALU result.
- `data_out` output `WORD_LEN`: registered load data.
- `misalign` output 1: registered misaligned-access flag; constant 0 without the macro.

## Operation
- Request: `req = MEM_R_EN | MEM_W_EN`.
- Word index: `ALU_res[log2(DEPTH)+1:2]`. Higher address bits are ignored, so addresses wrap modulo `4*DEPTH`.
- Counter `cnt`: 0 … `WAIT_STATES`. States:
  - IDLE (`cnt == 0`, no access pending).
  - BUSY (`cnt > 0`).
- Freeze: `freeze = req & (cnt != WAIT_STATES)`.
  - While `freeze` is high, `cnt` increments each edge.
  - On the first edge with `freeze` low and `req` high (completion edge), the access commits and `cnt` returns to 0.
- Upstream holds all inputs stable while `freeze` is high.
- Non-memory instruction (`req == 0`): passes in one cycle, `freeze` stays 0.
- Store commit: `mem[index] <= ST_value` on the completion edge only.
- Load commit: `data_out <= mem[index]` on the completion edge.
- Simultaneous `MEM_R_EN` and `MEM_W_EN`: treated as a store. `data_out` captures the pre-write word. `MEM_R_EN_out` is 0.
- MEM/WB register, when `freeze` is low: each edge captures `WB_EN_in`, `MEM_R_EN`, `dest_in`, `ALU_res` and the load data.
- MEM/WB register, when `freeze` is high: inserts a bubble.
  - `WB_EN_out` and `MEM_R_EN_out` are cleared to 0.
  - `dest_out`, `ALU_res_out` and `data_out` hold their values.
- Memory contents are not reset.

## Timing
- Reset values: all registered outputs 0; `cnt` 0; `freeze` follows inputs combinationally.
- Reset asserted mid-access: the access is aborted, no write occurs, and the next request after release starts at `cnt == 0`.
- Load/store latency: `WAIT_STATES+1` cycles from input valid to the MEM/WB capture edge.
- `freeze` is high for exactly `WAIT_STATES` cycles per access.
- Non-memory latency: 1 cycle.
- `WAIT_STATES == 0`: `freeze` is never asserted; every access completes in one cycle.
- Back-to-back accesses: the next request's counting starts the cycle after completion, so there are no idle cycles between accesses.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - A request with `ALU_res[1:0] != 0` completes immediately with no freeze and no write.
  - It registers `misalign = 1`, `WB_EN_out = 0`, `MEM_R_EN_out = 0`, `data_out = 0`.
  - `misalign` is 0 for every other instruction.
- `MEM_ALIGN_CHECK_EN` undefined: `ALU_res[1:0]` is ignored, all accesses proceed normally, and `misalign` is tied to 0.

## Test plan
- `WAIT_STATES = 2`, store `0xDEADBEEF` at address `0x10` -> `freeze` high 2 cycles then low. `mem[4] = 0xDEADBEEF` after the third edge. `WB_EN_out` is 0 during the stall.
- Load from `0x10` after that store, with `WB_EN_in = 1`, `dest_in = 7` -> `freeze` high 2 cycles. On completion: `data_out = 0xDEADBEEF`, `MEM_R_EN_out = 1`, `WB_EN_out = 1`, `dest_out = 7`.
- ALU instruction, `ALU_res = 0x1234`, `WB_EN_in = 1` -> `freeze` stays 0. `ALU_res_out = 0x1234` and `WB_EN_out = 1` next cycle.
- `rst` low after the first wait cycle of a store to `0x20` -> all outputs 0 and `mem[8]` unchanged. After release, a load of `0x20` takes a full 3 cycles.
- `DEPTH = 64`, store `0x55` to address `0x100` then load `0x000` -> returns `0x55` (wrap).
- With `MEM_ALIGN_CHECK_EN`, load from `0x13` -> no freeze; `misalign = 1`, `WB_EN_out = 0`, `data_out = 0` next cycle.
